mem_responder: RTL and testbench

- Memory-side responder for the core's load/store and fetch requests.
- Accepts one request at a time over a valid/ready handshake, waits a programmable latency, then returns read data or a write acknowledgement over a valid/ready response channel.
- Sits between the core (initiator) and a word-organised RAM array held internally.
- Replaces the zero-latency combinational memory path so the core can be moved to multi-cycle operation.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_responder_if.sv | 25 ++
 rtl/lfsr8.sv | 15 +
 rtl/mem_responder.sv | 162 ++++++++++++++++
 tb/tb_mem_responder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder (state encoding, widths, LFSR setup).
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned MASK_W = 8;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 5;

  localparam logic [ADDR_W-1:0] BASE_ADDR_DEF = 64'h8000_0000;

  // x^8+x^6+x^5+x^4+1 taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Misaligned, below base, or past the last word of the array.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input int unsigned       depth);
    logic [ADDR_W-1:0] off;
    off = addr - base;
    return (addr[2:0] != 3'd0) || (addr < base) || ((off >> 3) >= ADDR_W'(depth));
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel between the core (master) and the memory responder (slave).
interface mem_responder_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wen;
  logic [WORD_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to jitter the response latency.
module lfsr8
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= LFSR_SEED;
    else     out <= {out[6:0], ^(out & LFSR_TAPS)};
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable latency over a word-organised RAM.
// Define MEM_RAND_DELAY_EN to add LFSR-driven extra latency (0..15 cycles) per request.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned       DATA_WIDTH = 64,
  parameter int unsigned       DEPTH      = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter int unsigned       LATENCY    = 2
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  lat_load;
  logic              ready_q;
  logic              rsp_valid_q;
  logic [WORD_W-1:0] rdata_q;
  logic              err_q;

  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [WORD_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;

  logic              accept;
  logic              enter_resp;
  logic              rsp_done;

  logic [ADDR_W-1:0] cur_addr;
  logic              cur_wen;
  logic [WORD_W-1:0] cur_wdata;
  logic [MASK_W-1:0] cur_wmask;
  logic              cur_err;
  logic [IDX_W-1:0]  cur_idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef MEM_RAND_DELAY_EN
  logic [7:0] lfsr_out;

  lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (lfsr_out)
  );

  assign lat_load = CNT_W'(LATENCY) + CNT_W'(lfsr_out[3:0]);
`else
  assign lat_load = CNT_W'(LATENCY);
`endif

  assign accept   = bus.req_valid && ready_q;
  assign rsp_done = (state_q == RESP) && bus.rsp_ready;

  // With zero latency the array is accessed on the accept edge, before the request is captured.
  always_comb begin
    cur_addr  = addr_q;
    cur_wen   = wen_q;
    cur_wdata = wdata_q;
    cur_wmask = wmask_q;
    if (state_q == IDLE) begin
      cur_addr  = bus.req_addr;
      cur_wen   = bus.req_wen;
      cur_wdata = bus.req_wdata;
      cur_wmask = bus.req_wmask;
    end
    cur_err = addr_err(cur_addr, BASE_ADDR, DEPTH);
    cur_idx = IDX_W'((cur_addr - BASE_ADDR) >> 3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (lat_load == '0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = lat_load;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      ready_q <= (state_d == IDLE);
      if (accept) begin
        addr_q  <= bus.req_addr;
        wen_q   <= bus.req_wen;
        wdata_q <= bus.req_wdata;
        wmask_q <= bus.req_wmask;
      end
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        err_q       <= cur_err;
        rdata_q     <= (cur_err || cur_wen) ? '0 : WORD_W'(mem[cur_idx]);
      end else if (rsp_done) begin
        rsp_valid_q <= 1'b0;
        rdata_q     <= '0;
        err_q       <= 1'b0;
      end
    end
  end

  // Array write happens only on the RESP-entry edge, so stalls never repeat it.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_wen && !cur_err && !rst) begin
      for (int unsigned b = 0; b < MASK_W; b++) begin
        if (cur_wmask[b]) mem[cur_idx][b*BYTE_W +: BYTE_W] <= cur_wdata[b*BYTE_W +: BYTE_W];
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, corner sequences, randomized ops vs. a word-array model.
module tb_mem_responder;
  import mem_pkg::*;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int unsigned DEPTH = 4096;
  localparam int          NREF  = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mem_responder_if bus ();
  mem_responder_if bus0 ();

  mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        tbl [14];
  logic [63:0] ref_mem [NREF];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic model_err(input logic [63:0] addr);
    if (addr % 8 != 0) return 1'b1;
    if (addr < BASE) return 1'b1;
    return ((addr - BASE) / 8) >= 64'(DEPTH);
  endfunction

  // Issue one request on the LATENCY=2 instance; hold rsp_ready low for 'hold' cycles after rsp_valid.
  task automatic do_req(input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
                        input logic [7:0] wmask, input int hold,
                        output logic [63:0] rdata, output logic err, output int lat);
    int t;
    @(negedge clk);
    t = 0;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) chk("req_ready timeout", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_wen   = wen;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 50);
    if (!bus.rsp_valid) chk("rsp_valid timeout", bus.rsp_valid, 1);
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold rsp_valid", bus.rsp_valid, 1);
      chk("hold rsp_rdata", bus.rsp_rdata, rdata);
      chk("hold rsp_err", bus.rsp_err, err);
      chk("hold req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    chk("rsp_valid drop", bus.rsp_valid, 0);
  endtask

  task automatic chk_lat(input int lat, input int exp);
`ifndef MEM_RAND_DELAY_EN
    chk("latency", 64'(lat), 64'(exp));
`endif
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_d;
    logic        exp_e;
    int          idx;
    int          sel;

    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wen = 1'b0;
    bus.req_wdata = '0;   bus.req_wmask = '0; bus.rsp_ready = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_addr = '0; bus0.req_wen = 1'b0;
    bus0.req_wdata = '0;   bus0.req_wmask = '0; bus0.rsp_ready = 1'b0;

    tbl[0]  = '{BASE + 64'h10,   1'b1, 64'h1122334455667788, 8'hFF, 64'h0,                1'b0};
    tbl[1]  = '{BASE + 64'h10,   1'b0, 64'h0,                8'h00, 64'h1122334455667788, 1'b0};
    tbl[2]  = '{BASE + 64'h10,   1'b1, 64'hAAAAAAAABBBBBBBB, 8'h0F, 64'h0,                1'b0};
    tbl[3]  = '{BASE + 64'h10,   1'b0, 64'h0,                8'h00, 64'h11223344BBBBBBBB, 1'b0};
    tbl[4]  = '{BASE + 64'h4,    1'b0, 64'h0,                8'h00, 64'h0,                1'b1};
    tbl[5]  = '{64'h7FFF_FFF8,   1'b0, 64'h0,                8'h00, 64'h0,                1'b1};
    tbl[6]  = '{BASE + 64'h8000, 1'b0, 64'h0,                8'h00, 64'h0,                1'b1};
    tbl[7]  = '{BASE + 64'h10,   1'b1, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0,                1'b0};
    tbl[8]  = '{BASE + 64'h10,   1'b0, 64'h0,                8'h00, 64'h11223344BBBBBBBB, 1'b0};
    tbl[9]  = '{BASE + 64'h7FF8, 1'b1, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0,                1'b0};
    tbl[10] = '{BASE + 64'h7FF8, 1'b0, 64'h0,                8'h00, 64'hDEADBEEFCAFEF00D, 1'b0};
    tbl[11] = '{BASE,            1'b1, 64'h0,                8'hFF, 64'h0,                1'b0};
    tbl[12] = '{BASE + 64'h4,    1'b1, 64'h5555555555555555, 8'hFF, 64'h0,                1'b1};
    tbl[13] = '{BASE,            1'b0, 64'h0,                8'h00, 64'h0,                1'b0};

    // Outputs must be cleared while reset is held.
    #1;
    chk("reset req_ready", bus.req_ready, 0);
    chk("reset rsp_valid", bus.rsp_valid, 0);
    chk("reset rsp_rdata", bus.rsp_rdata, 0);
    chk("reset rsp_err", bus.rsp_err, 0);
    repeat (3) @(negedge clk);
    chk("reset req_ready held", bus.req_ready, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      do_req(tbl[i].addr, tbl[i].wen, tbl[i].wdata, tbl[i].wmask, 0, rd, er, lat);
      chk($sformatf("tbl%0d rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d err", i), er, tbl[i].exp_err);
      chk_lat(lat, 3);
    end

    // Backpressure: response stays put for 10 stalled cycles.
    do_req(BASE + 64'h18, 1'b1, 64'h0102030405060708, 8'hFF, 10, rd, er, lat);
    chk("bp write rdata", rd, 0);
    chk("bp write err", er, 0);
    do_req(BASE + 64'h18, 1'b0, 64'h0, 8'h00, 10, rd, er, lat);
    chk("bp read rdata", rd, 64'h0102030405060708);

    // Reset during WAIT abandons the write.
    do_req(BASE + 64'h20, 1'b1, 64'h0F0F0F0F0F0F0F0F, 8'hFF, 0, rd, er, lat);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = BASE + 64'h20; bus.req_wen = 1'b1;
    bus.req_wdata = 64'hEEEEEEEEEEEEEEEE; bus.req_wmask = 8'hFF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst-wait rsp_valid", bus.rsp_valid, 0);
    chk("rst-wait req_ready", bus.req_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_req(BASE + 64'h20, 1'b0, 64'h0, 8'h00, 0, rd, er, lat);
    chk("rst-wait prior data", rd, 64'h0F0F0F0F0F0F0F0F);

    // Reset while a stalled response is presented clears it without a clock edge.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = BASE + 64'h20; bus.req_wen = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-rst rsp_valid", bus.rsp_valid, 1);
    chk("pre-rst rsp_rdata", bus.rsp_rdata, 64'h0F0F0F0F0F0F0F0F);
    #2 rst = 1'b1;
    #1;
    chk("async rst rsp_valid", bus.rsp_valid, 0);
    chk("async rst rsp_rdata", bus.rsp_rdata, 0);
    chk("async rst req_ready", bus.req_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Zero-latency instance: response one cycle after the handshake.
    for (int i = 0; i < 2; i++) begin
      int t;
      @(negedge clk);
      t = 0;
      while (!bus0.req_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      bus0.req_valid = 1'b1; bus0.req_addr = BASE + 64'h40; bus0.req_wen = (i == 0);
      bus0.req_wdata = 64'h0123456789ABCDEF; bus0.req_wmask = 8'hFF;
      @(posedge clk);
      #1 bus0.req_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("lat0 op%0d rsp_valid", i), bus0.rsp_valid, 1);
      chk($sformatf("lat0 op%0d rdata", i), bus0.rsp_rdata, (i == 0) ? 64'h0 : 64'h0123456789ABCDEF);
      chk($sformatf("lat0 op%0d err", i), bus0.rsp_err, 0);
      bus0.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus0.rsp_ready = 1'b0;
    end

    // Randomized traffic against the word-array model: initialise a window, then mix ops.
    for (int i = 0; i < NREF; i++) begin
      ref_mem[i] = {$urandom, $urandom};
      do_req(BASE + 64'(i * 8), 1'b1, ref_mem[i], 8'hFF, 0, rd, er, lat);
      chk("init err", er, 0);
    end
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      idx = $urandom_range(0, NREF - 1);
      case (sel)
        0:       addr = BASE + 64'(idx * 8) + 64'($urandom_range(1, 7));
        1:       addr = BASE - 64'(8 * $urandom_range(1, 4));
        2:       addr = BASE + 64'(DEPTH * 8) + 64'(8 * $urandom_range(0, 3));
        default: addr = BASE + 64'(idx * 8);
      endcase
      wen   = $urandom_range(0, 1) == 1;
      wdata = {$urandom, $urandom};
      wmask = 8'($urandom);
      exp_e = model_err(addr);
      exp_d = 64'h0;
      if (!exp_e) begin
        idx = int'((addr - BASE) / 8);
        if (wen) begin
          for (int b = 0; b < 8; b++)
            if (wmask[b]) ref_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
        end else begin
          exp_d = ref_mem[idx];
        end
      end
      do_req(addr, wen, wdata, wmask, $urandom_range(0, 3), rd, er, lat);
      chk($sformatf("rand%0d rdata @%h", n, addr), rd, exp_d);
      chk($sformatf("rand%0d err @%h", n, addr), er, exp_e);
      chk_lat(lat, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
